// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider, one quotient bit per clock.
// Signed/unsigned operation, truncating quotient, remainder carries the dividend's sign,
// optional fixed-point quotient bits and a defined divide-by-zero result.
// Optional feature macro: SEQ_DIV_DBZ_FLAG_EN adds the registered div_by_zero output.
module seq_divider #(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 0,
  parameter int USE_CLA     = 1
) (
  input  logic               ctl_clk,
  input  logic               reset,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  input  logic               signed_cal,
  input  logic               trigger,
  output logic               ready,
  output logic               done,
  output logic [C_WIDTH-1:0] q,
  output logic [C_WIDTH-1:0] r
`ifdef SEQ_DIV_DBZ_FLAG_EN
  ,
  output logic               div_by_zero
`endif
);

  localparam int N  = C_WIDTH + FIXED_POINT;
  localparam int DW = N;
  localparam int SW = C_WIDTH + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [C_WIDTH-1:0] rem;
  logic [DW-1:0]      quo;
  logic [C_WIDTH-1:0] b_mag_r;
  logic [C_WIDTH-1:0] a_raw;
  logic               sign_q, sign_r, b_zero;
  logic               accept;
  logic [C_WIDTH-1:0] a_mag, b_mag;
  logic [SW-1:0]      trial_a, trial_b, trial_diff;
  logic               trial_ok;
  logic [C_WIDTH-1:0] rem_next;
  logic               unused_diff_msb;

  // The dividend is pre-shifted into the quotient register so fractional bits come for free.
  assign a_mag  = (signed_cal && a[C_WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag  = (signed_cal && b[C_WIDTH-1]) ? (~b + 1'b1) : b;
  assign accept = ready && trigger;

  // Trial subtraction: {rem, next dividend bit} - |b|, carry out means no borrow.
  assign trial_a = {rem, quo[DW-1]};
  assign trial_b = ~{1'b0, b_mag_r};

  generate
    if (USE_CLA != 0) begin : g_cla
      assign {trial_ok, trial_diff} = {1'b0, trial_a} + {1'b0, trial_b} + {{SW{1'b0}}, 1'b1};
    end else begin : g_rca
      logic [SW:0] c;
      assign c[0] = 1'b1;
      for (genvar i = 0; i < SW; i++) begin : g_bit
        assign trial_diff[i] = trial_a[i] ^ trial_b[i] ^ c[i];
        assign c[i+1]        = (trial_a[i] & trial_b[i]) | (c[i] & (trial_a[i] ^ trial_b[i]));
      end
      assign trial_ok = c[SW];
    end
  endgenerate

  // A successful subtraction always leaves a value below |b|, so the top bit is never needed.
  assign rem_next        = trial_ok ? trial_diff[C_WIDTH-1:0] : trial_a[C_WIDTH-1:0];
  assign unused_diff_msb = trial_diff[SW-1];

  // State register.
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake decode; ready/done depend on state only.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (trigger) state_next = CALC;
      end
      CALC: begin
        if (cnt == CW'(1)) state_next = FIX;
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = trigger ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one restoring step per CALC cycle, sign fix-up in FIX.
  always_ff @(posedge ctl_clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      b_mag_r <= '0;
      a_raw   <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      b_zero  <= 1'b0;
      q       <= '0;
      r       <= '0;
`ifdef SEQ_DIV_DBZ_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end else if (accept) begin
      cnt     <= CW'(N);
      rem     <= '0;
      quo     <= DW'(a_mag) << FIXED_POINT;
      b_mag_r <= b_mag;
      a_raw   <= a;
      sign_q  <= (a[C_WIDTH-1] ^ b[C_WIDTH-1]) & signed_cal;
      sign_r  <= a[C_WIDTH-1] & signed_cal;
      b_zero  <= (b == '0);
`ifdef SEQ_DIV_DBZ_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end else if (state == CALC) begin
      rem <= rem_next;
      quo <= {quo[DW-2:0], trial_ok};
      cnt <= cnt - CW'(1);
    end else if (state == FIX) begin
      if (b_zero) begin
        q <= '1;
        r <= a_raw;
      end else begin
        q <= sign_q ? (~quo[C_WIDTH-1:0] + 1'b1) : quo[C_WIDTH-1:0];
        r <= sign_r ? (~rem + 1'b1) : rem;
      end
`ifdef SEQ_DIV_DBZ_FLAG_EN
      div_by_zero <= b_zero;
`endif
    end
  end

endmodule
